// File: rtl/switch_fifo.sv
// switch_fifo: button-driven byte queue. The push button captures the switch
// bits and the pop button moves the oldest entry onto the green LEDs. The red
// LEDs preview the head entry. Both buttons are synchronised and
// edge-detected, so each press acts exactly once.
module switch_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         switches,
    input  logic                     push_button,
    input  logic                     pop_button,
    output logic [WIDTH-1:0]         green_leds,
    output logic [WIDTH-1:0]         red_leds,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic push_r1_q, push_r2_q, push_r3_q;
    logic push_r1_d, push_r2_d, push_r3_d;
    logic pop_r1_q, pop_r2_q, pop_r3_q;
    logic pop_r1_d, pop_r2_d, pop_r3_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] green_leds_q, green_leds_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic push_pulse, pop_pulse;
    logic do_push, do_pop;
    logic is_empty, is_full;

    // Synchroniser chains: three flops per button, pulse taken from the last two.
    always_comb begin
        push_r1_d = push_button;
        push_r2_d = push_r1_q;
        push_r3_d = push_r2_q;
        pop_r1_d  = pop_button;
        pop_r2_d  = pop_r1_q;
        pop_r3_d  = pop_r2_q;
    end

    assign push_pulse = push_r2_q & ~push_r3_q;
    assign pop_pulse  = pop_r2_q & ~pop_r3_q;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // A pop on a full queue frees the slot, so the simultaneous push is kept;
    // a pop on an empty queue never reads through the same-edge push.
    assign do_pop  = pop_pulse & ~is_empty;
    assign do_push = push_pulse & (~is_full | pop_pulse);

    // Next-state for pointers, occupancy, output latch and sticky error flags.
    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        green_leds_d = green_leds_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (do_push) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (do_pop) begin
            rp_d         = rp_q + PTR_ONE;
            green_leds_d = mem_q[rp_q];
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (push_pulse && is_full && !pop_pulse) begin
            overflow_d = 1'b1;
        end
        if (pop_pulse && is_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control and conditioning registers, synchronously cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push_r1_q    <= 1'b0;
            push_r2_q    <= 1'b0;
            push_r3_q    <= 1'b0;
            pop_r1_q     <= 1'b0;
            pop_r2_q     <= 1'b0;
            pop_r3_q     <= 1'b0;
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            green_leds_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            push_r1_q    <= push_r1_d;
            push_r2_q    <= push_r2_d;
            push_r3_q    <= push_r3_d;
            pop_r1_q     <= pop_r1_d;
            pop_r2_q     <= pop_r2_d;
            pop_r3_q     <= pop_r3_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            green_leds_q <= green_leds_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array is not reset; writes are suppressed while reset is low.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem_q[wp_q] <= switches;
        end
    end

    assign green_leds = green_leds_q;
    assign red_leds   = is_empty ? '0 : mem_q[rp_q];
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_switch_fifo.sv
// Directed bench for switch_fifo: ordering, full/wrap, overflow, underflow,
// simultaneous push/pop, held button and reset with a pending pop.
module tb_switch_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] switches = 8'h00;
    logic       push_button = 1'b0;
    logic       pop_button = 1'b0;
    logic [7:0] green_leds;
    logic [7:0] red_leds;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    switch_fifo #(.DEPTH(8), .WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .switches    (switches),
        .push_button (push_button),
        .pop_button  (pop_button),
        .green_leds  (green_leds),
        .red_leds    (red_leds),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        push_button = 1'b0;
        pop_button  = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic press(input logic psh, input logic pp, input logic [7:0] val);
        switches    = val;
        push_button = psh;
        pop_button  = pp;
        tick(5);
        push_button = 1'b0;
        pop_button  = 1'b0;
        tick(5);
    endtask

    task automatic push_val(input logic [7:0] val);
        press(1'b1, 1'b0, val);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp_green);
        press(1'b0, 1'b1, switches);
        check_val(tag, green_leds, exp_green);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_val("rst_green", green_leds, 8'h00);
        check_val("rst_red", red_leds, 8'h00);
        check_val("rst_count", count, 4'd0);
        check_val("rst_empty", empty, 1'b1);
        check_val("rst_full", full, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        check_val("rst_unf", underflow, 1'b0);
        reset = 1'b1;
        tick(1);

        // Ordering
        push_val(8'hA5);
        push_val(8'h3C);
        push_val(8'hF0);
        check_val("ord_count", count, 4'd3);
        check_val("ord_red", red_leds, 8'hA5);
        pop_expect("ord_pop0", 8'hA5);
        check_val("ord_red0", red_leds, 8'h3C);
        pop_expect("ord_pop1", 8'h3C);
        check_val("ord_red1", red_leds, 8'hF0);
        pop_expect("ord_pop2", 8'hF0);
        check_val("ord_red2", red_leds, 8'h00);
        check_val("ord_empty", empty, 1'b1);

        // Full, overflow and wrap
        for (int i = 1; i <= 8; i++) push_val(8'(i));
        check_val("full_flag", full, 1'b1);
        check_val("full_count", count, 4'd8);
        push_val(8'h09);
        check_val("ovf_flag", overflow, 1'b1);
        check_val("ovf_count", count, 4'd8);
        pop_expect("wrap_pop01", 8'h01);
        pop_expect("wrap_pop02", 8'h02);
        push_val(8'h10);
        push_val(8'h11);
        check_val("wrap_count", count, 4'd8);
        for (int i = 3; i <= 8; i++) pop_expect("wrap_pop", 8'(i));
        pop_expect("wrap_pop10", 8'h10);
        pop_expect("wrap_pop11", 8'h11);
        check_val("wrap_empty", empty, 1'b1);

        // Underflow
        pop_expect("unf_green", 8'h11);
        check_val("unf_count", count, 4'd0);
        check_val("unf_flag", underflow, 1'b1);

        // Simultaneous push/pop, partially filled
        push_val(8'h22);
        push_val(8'h33);
        press(1'b1, 1'b1, 8'h44);
        check_val("sim_green", green_leds, 8'h22);
        check_val("sim_count", count, 4'd2);
        check_val("sim_red", red_leds, 8'h33);
        pop_expect("sim_pop33", 8'h33);
        pop_expect("sim_pop44", 8'h44);
        check_val("unf_sticky", underflow, 1'b1);

        // Simultaneous push/pop on a full queue
        do_reset();
        check_val("rst2_ovf", overflow, 1'b0);
        check_val("rst2_unf", underflow, 1'b0);
        for (int i = 0; i < 8; i++) push_val(8'h51 + 8'(i));
        press(1'b1, 1'b1, 8'h99);
        check_val("simf_green", green_leds, 8'h51);
        check_val("simf_count", count, 4'd8);
        check_val("simf_ovf", overflow, 1'b0);
        check_val("simf_red", red_leds, 8'h52);
        for (int i = 1; i < 8; i++) pop_expect("simf_pop", 8'h51 + 8'(i));
        pop_expect("simf_pop99", 8'h99);
        check_val("simf_empty", empty, 1'b1);

        // Held push button
        switches    = 8'h77;
        push_button = 1'b1;
        tick(50);
        push_button = 1'b0;
        tick(5);
        check_val("held_count", count, 4'd1);
        check_val("held_red", red_leds, 8'h77);

        // Reset with a pending pop pulse
        push_val(8'h78);
        push_val(8'h79);
        check_val("pend_count", count, 4'd3);
        pop_button = 1'b1;
        tick(2);
        reset      = 1'b0;
        pop_button = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(6);
        check_val("pend_green", green_leds, 8'h00);
        check_val("pend_red", red_leds, 8'h00);
        check_val("pend_count0", count, 4'd0);
        check_val("pend_empty", empty, 1'b1);
        check_val("pend_full", full, 1'b0);
        check_val("pend_ovf", overflow, 1'b0);
        check_val("pend_unf", underflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_fifo.md
# switch_fifo

Button-driven byte FIFO for the board seminar designs, and the reading end of the switch-capture path. A push button captures the 8 switch bits into a DEPTH-entry queue. A pop button removes the oldest entry and latches it onto the green LEDs. The red LEDs always preview the entry that the next pop will return. Both buttons pass through on-chip synchronisers and rising-edge detectors, so each press acts exactly once.

## Interface
Parameters:
- DEPTH, 8, number of entries; must be a power of two, 2..16
- WIDTH, 8, data width in bits

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-low
- switches  input  WIDTH  data captured on push
- push_button  input  1  asynchronous, active-high
- pop_button  input  1  asynchronous, active-high
- green_leds  output  WIDTH  last popped value (registered)
- red_leds  output  WIDTH  head entry preview; 0 when empty
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky; a push was dropped
- underflow  output  1  sticky; a pop hit an empty queue

## Operation
Button conditioning:
- Each button has its own chain of three flops: `b_r1 <= button`, `b_r2 <= b_r1`, `b_r3 <= b_r2`.
- The pulse is `b_r2 & ~b_r3`, which is one clock wide per rising edge.
- Conditioning flops reset to 0. A button already held high when reset is released therefore produces one pulse.

Storage:
- Register array `mem[DEPTH]`.
- Write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH naturally.
- `count` is a separate register. The storage array itself is not reset.

Actions on each edge, evaluated from the current count:
- Push only:
  - If not full: `mem[wp] <= switches`, `wp++`, `count++`.
  - If full: drop the push and set `overflow`.
- Pop only:
  - If not empty: `green_leds <= mem[rp]`, `rp++`, `count--`.
  - If empty: leave `green_leds` unchanged and set `underflow`.
- Push and pop on the same edge:
  - Empty: do the push only. The pop is an underflow; there is no read-through.
  - Neither empty nor full: do both. `count` is unchanged and `green_leds` receives the old head.
  - Full: do both. The pop reads the old `mem[rp]` before the write to the same slot takes effect. `count` stays at DEPTH and no overflow is flagged.

Outputs:
- `red_leds = empty ? 0 : mem[rp]`, combinational from registers.
- `empty` and `full` are decoded combinationally from `count`.
- `overflow` and `underflow` are cleared only by reset.

Reset (reset == 0 at an edge):
- `green_leds = 0`, `count = 0`, `wp = rp = 0`, `overflow = underflow = 0`.
- Conditioning flops = 0.
- Consequently `red_leds = 0`, `empty = 1`, `full = 0`.
- Reset overrides any pending pulse.

## Timing
- Suppose a button is first sampled high at edge k.
  - `b_r2` rises after edge k+1.
  - The pulse is high from edge k+1 to edge k+2.
  - The action commits at edge k+2, so `count`, `green_leds` and `red_leds` show new values after edge k+2.
- A button held high for N cycles gives exactly one action.
- Minimum press spacing:
  - One high sample followed by one low sample re-arms the detector.
  - The button is not debounced, so contact bounce yields multiple actions. Board-level debounce is outside this block.
- Throughput is at most one push and one pop per clock.
- `red_leds` reflects a new head in the same cycle the pointers or count update.

## Test plan
- Reset: hold reset low for 3 cycles with both buttons low. Require green = 0, red = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
- Ordering: push 0xA5, 0x3C, 0xF0, each held 5 cycles with 5 low cycles between.
  - Then require count = 3 and red = 0xA5.
  - Pop three times. Green must show 0xA5, 0x3C, 0xF0 in turn, red must step 0x3C, 0xF0, 0x00, and empty = 1 at the end.
- Full and wrap: push 0x01 through 0x08, then require full = 1 and count = 8.
  - Push 0x09: require overflow = 1 and count = 8.
  - Pop twice, then push 0x10 and 0x11. Popping everything must return 01..08 except the first two, followed by 0x10 and 0x11.
- Underflow: pop with the queue empty. Require green unchanged, count = 0, and underflow = 1 held until reset.
- Simultaneous edges:
  - Queue holds [0x22, 0x33]. Press both buttons on the same cycle with switches = 0x44. Require green = 0x22, count = 2, red = 0x33, then later pops return 0x33 and 0x44.
  - Repeat with the queue full: require count = 8 and overflow = 0.
- Held button and reset mid-operation:
  - Holding push for 50 cycles adds exactly one entry.
  - Assert reset while the queue holds 3 entries and a pop pulse is pending. Require all reset values, and no pop occurs after release.
